// File: rtl/uart_if_clocking.sv
// uart_if_clocking: synchronizes raw UART pins onto clk, decodes 8N1 frames,
// measures low-run widths and flags line breaks. Rev 1.0
`default_nettype none

module uart_if_clocking #(
  parameter int CLK_FREQ_HZ = 125_000_000,
  parameter int BAUD_RATE   = 115200,
  parameter int BIT_CYCLES  = CLK_FREQ_HZ / BAUD_RATE,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             uart_rx,
  input  logic             uart_cts_n,
  output logic             mon_rx,
  output logic             mon_cts_n,
  output logic             tx_allowed,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             frame_err,
  output logic [CNT_W-1:0] low_run_cycles,
  output logic             low_run_valid,
  output logic             break_det,
  output logic             busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;

  localparam logic [CNT_W-1:0] C_BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_HALF_LAST = CNT_W'(BIT_CYCLES / 2 - 1);
  localparam logic [CNT_W-1:0] C_BREAK     = CNT_W'(11 * BIT_CYCLES);
  localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);

  logic [1:0]       rx_sync_q, cts_sync_q;
  logic             rx_prev_q;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_err_q, frame_err_d;
  logic [CNT_W-1:0] low_cnt_q, low_cnt_d;
  logic [CNT_W-1:0] low_run_q, low_run_d;
  logic             low_run_valid_q, low_run_valid_d;
  logic             break_q, break_d;

  assign mon_rx         = rx_sync_q[1];
  assign mon_cts_n      = cts_sync_q[1];
  assign tx_allowed     = ~cts_sync_q[1];
  assign rx_data        = rx_data_q;
  assign rx_valid       = rx_valid_q;
  assign frame_err      = frame_err_q;
  assign low_run_cycles = low_run_q;
  assign low_run_valid  = low_run_valid_q;
  assign break_det      = break_q;
  assign busy           = (state_q != S_IDLE);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rx_prev_q && !mon_rx) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        // A start bit that is high again at mid-bit is treated as a glitch.
        if (cnt_q == C_HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = 3'd0;
          state_d = mon_rx ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + C_ONE;
        end
      end
      S_DATA: begin
        if (cnt_q == C_BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {mon_rx, shift_q[7:1]};
          if (idx_q == 3'd7) state_d = S_STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + C_ONE;
        end
      end
      S_STOP: begin
        if (cnt_q == C_BIT_LAST) begin
          cnt_d = '0;
          if (mon_rx) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            state_d    = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_WAIT;
          end
        end else begin
          cnt_d = cnt_q + C_ONE;
        end
      end
      S_WAIT: begin
        if (mon_rx) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    low_cnt_d       = low_cnt_q;
    low_run_d       = low_run_q;
    low_run_valid_d = 1'b0;
    break_d         = break_q;
    if (!mon_rx) begin
      if (low_cnt_q != '1) low_cnt_d = low_cnt_q + C_ONE;
      if (low_cnt_q >= C_BREAK) break_d = 1'b1;
    end else begin
      low_cnt_d = '0;
      break_d   = 1'b0;
      if (!rx_prev_q) begin
        low_run_d       = low_cnt_q;
        low_run_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_sync_q       <= 2'b11;
      cts_sync_q      <= 2'b11;
      rx_prev_q       <= 1'b1;
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      idx_q           <= 3'd0;
      shift_q         <= 8'h00;
      rx_data_q       <= 8'h00;
      rx_valid_q      <= 1'b0;
      frame_err_q     <= 1'b0;
      low_cnt_q       <= '0;
      low_run_q       <= '0;
      low_run_valid_q <= 1'b0;
      break_q         <= 1'b0;
    end else begin
      rx_sync_q       <= {rx_sync_q[0], uart_rx};
      cts_sync_q      <= {cts_sync_q[0], uart_cts_n};
      rx_prev_q       <= rx_sync_q[1];
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      idx_q           <= idx_d;
      shift_q         <= shift_d;
      rx_data_q       <= rx_data_d;
      rx_valid_q      <= rx_valid_d;
      frame_err_q     <= frame_err_d;
      low_cnt_q       <= low_cnt_d;
      low_run_q       <= low_run_d;
      low_run_valid_q <= low_run_valid_d;
      break_q         <= break_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_if_clocking.sv
// tb_uart_if_clocking: directed bench for uart_if_clocking, scaled to 16 clk per bit.
`default_nettype none

module tb_uart_if_clocking;

  localparam int BIT = 16;

  logic        clk;
  logic        rst;
  logic        uart_rx;
  logic        uart_cts_n;
  logic        mon_rx;
  logic        mon_cts_n;
  logic        tx_allowed;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        frame_err;
  logic [15:0] low_run_cycles;
  logic        low_run_valid;
  logic        break_det;
  logic        busy;

  uart_if_clocking #(
    .CLK_FREQ_HZ(1_600_000),
    .BAUD_RATE  (100_000),
    .CNT_W      (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .uart_rx       (uart_rx),
    .uart_cts_n    (uart_cts_n),
    .mon_rx        (mon_rx),
    .mon_cts_n     (mon_cts_n),
    .tx_allowed    (tx_allowed),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .frame_err     (frame_err),
    .low_run_cycles(low_run_cycles),
    .low_run_valid (low_run_valid),
    .break_det     (break_det),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  logic [7:0]  rx_q[$];
  logic [15:0] lr_q[$];
  int          fe_cnt = 0;
  int          brk_cnt = 0;
  int          last_rx_cyc = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_q.push_back(rx_data);
      last_rx_cyc = cyc;
    end
    if (frame_err) fe_cnt++;
    if (low_run_valid) lr_q.push_back(low_run_cycles);
    if (break_det) brk_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    uart_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    uart_rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    uart_rx = 1'b1;
    repeat (BIT) @(negedge clk);
  endtask

  logic [7:0] burst [5] = '{8'h5A, 8'hA1, 8'h12, 8'h34, 8'hBC};
  int rb, lb, fb, bb, t0;

  initial begin
    rst = 1'b0;
    uart_rx = 1'b1;
    uart_cts_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mon_rx", {31'd0, mon_rx}, 32'd1);
    check("rst_mon_cts_n", {31'd0, mon_cts_n}, 32'd1);
    check("rst_tx_allowed", {31'd0, tx_allowed}, 32'd0);
    check("rst_outputs", {rx_data, low_run_cycles, rx_valid, frame_err, low_run_valid,
                          break_det, busy}, 32'd0);

    rst = 1'b1;
    @(negedge clk);
    check("cts_lag1", {31'd0, mon_cts_n}, 32'd1);
    @(negedge clk);
    check("cts_lag2", {31'd0, mon_cts_n}, 32'd0);
    check("tx_allowed", {31'd0, tx_allowed}, 32'd1);
    idle(BIT);

    // Single byte 0xA5
    rb = rx_q.size(); lb = lr_q.size(); fb = fe_cnt;
    send_byte(8'hA5);
    idle(BIT);
    check("a5_count", rx_q.size() - rb, 32'd1);
    check("a5_data", {24'd0, rx_q[rb]}, 32'hA5);
    check("a5_no_ferr", fe_cnt - fb, 32'd0);
    check("a5_first_lowrun", {16'd0, lr_q[lb]}, BIT);

    // Five bytes with short gaps
    rb = rx_q.size(); t0 = cyc;
    for (int i = 0; i < 5; i++) begin
      send_byte(burst[i]);
      idle(6);
    end
    idle(BIT);
    check("burst_count", rx_q.size() - rb, 32'd5);
    for (int i = 0; i < 5; i++) check("burst_data", {24'd0, rx_q[rb+i]}, {24'd0, burst[i]});
    check("burst_time_ok", {31'd0, (last_rx_cyc - t0) < 100 * BIT}, 32'd1);

    // 0xFF: only the start bit is low
    rb = rx_q.size(); lb = lr_q.size(); t0 = cyc;
    send_byte(8'hFF);
    idle(BIT);
    check("ff_data", {24'd0, rx_q[rb]}, 32'hFF);
    check("ff_latency_ok", {31'd0, (last_rx_cyc - t0) < 10 * BIT}, 32'd1);
    check("ff_lowrun", {16'd0, lr_q[lb]}, BIT);

    // One bit time low then release: decodes as 0xFF, FSM back to idle
    rb = rx_q.size(); lb = lr_q.size();
    uart_rx = 1'b0;
    repeat (BIT) @(negedge clk);
    idle(12 * BIT);
    check("pulse_lowrun", {16'd0, lr_q[lb]}, BIT);
    check("pulse_idle", {31'd0, busy}, 32'd0);
    check("pulse_rx_count", rx_q.size() - rb, 32'd1);

    // Twenty bytes 0x00..0x13
    rb = rx_q.size(); bb = brk_cnt; t0 = cyc;
    for (int i = 0; i < 20; i++) begin
      send_byte(8'(i));
      idle(3);
    end
    idle(BIT);
    check("seq_count", rx_q.size() - rb, 32'd20);
    for (int i = 0; i < 20; i++) check("seq_data", {24'd0, rx_q[rb+i]}, i);
    check("seq_time_ok", {31'd0, (last_rx_cyc - t0) < 500 * BIT}, 32'd1);
    check("seq_no_break", brk_cnt - bb, 32'd0);

    // Break: 12 bit times low
    fb = fe_cnt;
    uart_rx = 1'b0;
    repeat (12 * BIT) @(negedge clk);
    check("brk_det", {31'd0, break_det}, 32'd1);
    check("brk_busy", {31'd0, busy}, 32'd1);
    check("brk_ferr", fe_cnt - fb, 32'd1);
    idle(4);
    check("brk_clear", {31'd0, break_det}, 32'd0);
    check("brk_idle", {31'd0, busy}, 32'd0);
    idle(BIT);

    // Reset in the middle of a frame
    rb = rx_q.size(); fb = fe_cnt;
    uart_rx = 1'b0;
    repeat (4 * BIT) @(negedge clk);
    check("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    uart_rx = 1'b1;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_mon_rx", {31'd0, mon_rx}, 32'd1);
    check("mid_rst_tx_allowed", {31'd0, tx_allowed}, 32'd0);
    check("mid_rst_data", {24'd0, rx_data}, 32'd0);
    check("mid_rst_lowrun", {16'd0, low_run_cycles}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle(12 * BIT);
    check("mid_no_rx", rx_q.size() - rb, 32'd0);
    check("mid_no_ferr", fe_cnt - fb, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
